// File: rtl/mem_sequencer_if.sv
// Bus between the phase sequencer and its data source / single-port RAM.
// The sequencer side takes the master modport; the source/RAM/observer side takes slave.
interface mem_sequencer_if #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned TIMER_WIDTH = 8
);
    logic                   dav;
    logic                   WriteEnable;
    logic                   MemoryEnable;
    logic                   ReadValid;
    logic [ADDR_WIDTH-1:0]  Address;
    logic [ADDR_WIDTH:0]    Count;
    logic                   Full;
    logic                   Empty;
    logic [TIMER_WIDTH-1:0] TimerValue;
    logic [1:0]             PresentStateFlag;

    modport master (
        input  dav,
        output WriteEnable, MemoryEnable, ReadValid, Address,
        output Count, Full, Empty, TimerValue, PresentStateFlag
    );

    modport slave (
        output dav,
        input  WriteEnable, MemoryEnable, ReadValid, Address,
        input  Count, Full, Empty, TimerValue, PresentStateFlag
    );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: Idle -> Write -> Read phase sequencer with an internal phase timer,
// wrapping write/read pointers and occupancy tracking for a 2^ADDR_WIDTH single-port RAM.
// Optional feature macro: SEQ_EARLY_EXIT_EN (leave Write when full, leave Read when empty).
module mem_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned TIMER_WIDTH = 8,
    parameter int unsigned IDLE_TICKS  = 5,
    parameter int unsigned WRITE_TICKS = 10,
    parameter int unsigned READ_TICKS  = 10
) (
    input  logic            clock1Hz,
    input  logic            reset,
    mem_sequencer_if.master bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [TIMER_WIDTH-1:0] IDLE_LAST  = TIMER_WIDTH'(IDLE_TICKS - 1);
    localparam logic [TIMER_WIDTH-1:0] WRITE_LAST = TIMER_WIDTH'(WRITE_TICKS - 1);
    localparam logic [TIMER_WIDTH-1:0] READ_LAST  = TIMER_WIDTH'(READ_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_BAD   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic [ADDR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_we;
    logic                   w_me;
    logic                   w_rv;
    logic                   w_early;
    logic [ADDR_WIDTH-1:0]  w_addr;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // State register; the unreachable encoding recovers through the next-state logic.
    always_ff @(posedge clock1Hz) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and RAM strobes: phase expiry, optional early exit, address mux.
    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_me         = 1'b0;
        w_rv         = 1'b0;
        w_early      = 1'b0;
        w_addr       = r_rd_ptr;
        case (r_state)
            S_IDLE: begin
                if (r_timer == IDLE_LAST) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_me   = 1'b1;
                w_addr = r_wr_ptr;
                w_we   = bus.dav & ~w_full;
`ifdef SEQ_EARLY_EXIT_EN
                w_early = w_we && (r_count == CNT_W'(DEPTH - 1));
`else
                w_early = 1'b0;
`endif
                if ((r_timer == WRITE_LAST) || w_early) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                w_me = 1'b1;
                w_rv = ~w_empty;
`ifdef SEQ_EARLY_EXIT_EN
                // Count can only be 0 here on entry, since draining to 0 exits at once.
                w_early = w_empty || (w_rv && (r_count == CNT_W'(1)));
`else
                w_early = 1'b0;
`endif
                if ((r_timer == READ_LAST) || w_early) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Phase timer, pointers and occupancy; reads and writes are mutually exclusive by phase.
    always_ff @(posedge clock1Hz) begin
        if (reset) begin
            r_timer  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_next_state != r_state) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TIMER_WIDTH'(1);
            end
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                r_count  <= r_count + CNT_W'(1);
            end else if (w_rv) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
                r_count  <= r_count - CNT_W'(1);
            end
        end
    end

    assign bus.WriteEnable      = w_we;
    assign bus.MemoryEnable     = w_me;
    assign bus.ReadValid        = w_rv;
    assign bus.Address          = w_addr;
    assign bus.Count            = r_count;
    assign bus.Full             = w_full;
    assign bus.Empty            = w_empty;
    assign bus.TimerValue       = r_timer;
    assign bus.PresentStateFlag = r_state;
endmodule
